// File: rtl/mac_sequencer_if.sv
// Bundle of the scheduler, memory, quadrant and result signals of mac_sequencer.
// master: the sequencer side. slave: the environment (scheduler, memories, quadrant, sink).
interface mac_sequencer_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned LEN_W  = 8
) ();
  logic              start;
  logic [LEN_W-1:0]  cfg_len;
  logic [ADDR_W-1:0] cfg_in_base;
  logic [ADDR_W-1:0] cfg_wt_base;
  logic              busy;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] in_addr;
  logic [ADDR_W-1:0] wt_addr;
  logic [15:0]       in_data;
  logic [15:0]       wt_data;
  logic [15:0]       mac_a;
  logic [15:0]       mac_b;
  logic              mac_clear;
  logic [31:0]       mac_acc;
  logic              res_valid;
  logic              res_ready;
  logic [15:0]       res_data;
  logic              res_sat;

  modport master (
    input  start, cfg_len, cfg_in_base, cfg_wt_base, in_data, wt_data, mac_acc, res_ready,
    output busy, mem_rd_en, in_addr, wt_addr, mac_a, mac_b, mac_clear, res_valid, res_data,
           res_sat
  );

  modport slave (
    output start, cfg_len, cfg_in_base, cfg_wt_base, in_data, wt_data, mac_acc, res_ready,
    input  busy, mem_rd_en, in_addr, wt_addr, mac_a, mac_b, mac_clear, res_valid, res_data,
           res_sat
  );
endinterface

// File: rtl/mac_sequencer.sv
// Sequences one quadrant MAC through a length-N dot product: reads paired input/weight
// words, feeds them to the quadrant, then returns the truncated accumulator.
// Optional feature: define SATURATE_EN to clamp the result instead of wrapping.
module mac_sequencer #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned SHIFT  = 8
) (
  input logic             clock,
  input logic             reset_n,
  mac_sequencer_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  // Cycles from the last operand pair until the accumulator holds the full sum.
  localparam int unsigned DrainLast = 2;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] in_base_q, wt_base_q;
  logic              rd_vld_q, rd_first_q;
  logic [15:0]       mac_a_q, mac_b_q;
  logic              mac_clear_q;
  logic [15:0]       res_data_q;
  logic [15:0]       res_next;
  logic              unused_acc;

  assign unused_acc = ^bus.mac_acc;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and phase counter; the counter restarts on every state change.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = (bus.cfg_len == '0) ? StDone : StRun;
      end
      StRun: begin
        if (cnt_q == LEN_W'(len_q - 1'b1)) state_d = StDrain;
      end
      StDrain: begin
        if (cnt_q == LEN_W'(DrainLast)) state_d = StDone;
      end
      StDone: begin
        if (bus.res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    if (state_q == StIdle || state_q == StDone) cnt_d = '0;
  end

  // Outputs decoded from state; addresses are held at zero outside RUN.
  always_comb begin
    bus.busy      = (state_q != StIdle);
    bus.mem_rd_en = (state_q == StRun);
    bus.res_valid = (state_q == StDone);
    bus.in_addr   = '0;
    bus.wt_addr   = '0;
    if (state_q == StRun) begin
      bus.in_addr = in_base_q + ADDR_W'(cnt_q);
      bus.wt_addr = wt_base_q + ADDR_W'(cnt_q);
    end
  end

  // Result formatting: plain slice, optionally clamped to the Q8.8 range.
  always_comb begin
    res_next = bus.mac_acc[SHIFT+15:SHIFT];
  end

`ifdef SATURATE_EN
  localparam int unsigned TopW = 32 - SHIFT - 15;

  logic [TopW-1:0] acc_top;
  logic            sat_next;
  logic            res_sat_q;
  logic [15:0]     res_fmt;

  assign acc_top = bus.mac_acc[31:SHIFT+15];

  // Out of range whenever the bits above the slice are not a pure sign extension.
  always_comb begin
    res_fmt  = res_next;
    sat_next = 1'b0;
    if (!bus.mac_acc[31] && (|acc_top)) begin
      res_fmt  = 16'h7fff;
      sat_next = 1'b1;
    end else if (bus.mac_acc[31] && !(&acc_top)) begin
      res_fmt  = 16'h8000;
      sat_next = 1'b1;
    end
  end

  // Saturation flag, captured together with the result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      res_sat_q <= 1'b0;
    end else if (state_q == StIdle && state_d == StDone) begin
      res_sat_q <= 1'b0;
    end else if (state_q == StDrain && state_d == StDone) begin
      res_sat_q <= sat_next;
    end
  end

  assign bus.res_sat = res_sat_q;
`else
  logic [15:0] res_fmt;

  assign res_fmt     = res_next;
  assign bus.res_sat = 1'b0;
`endif

  // Configuration latch, operand pipe and result register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      len_q       <= '0;
      in_base_q   <= '0;
      wt_base_q   <= '0;
      rd_vld_q    <= 1'b0;
      rd_first_q  <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_clear_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      if (state_q == StIdle && bus.start) begin
        len_q     <= bus.cfg_len;
        in_base_q <= bus.cfg_in_base;
        wt_base_q <= bus.cfg_wt_base;
      end
      // Read data arrives one cycle after the strobe; mark it and the first pair.
      rd_vld_q    <= (state_q == StRun);
      rd_first_q  <= (state_q == StRun) && (cnt_q == '0);
      // Zero operands when idle so the free-running accumulator holds its value.
      mac_a_q     <= rd_vld_q ? bus.in_data : '0;
      mac_b_q     <= rd_vld_q ? bus.wt_data : '0;
      mac_clear_q <= rd_vld_q && rd_first_q;
      if (state_q == StIdle && state_d == StDone) begin
        res_data_q <= '0;
      end else if (state_q == StDrain && state_d == StDone) begin
        res_data_q <= res_fmt;
      end
    end
  end

  assign bus.mac_a     = mac_a_q;
  assign bus.mac_b     = mac_b_q;
  assign bus.mac_clear = mac_clear_q;
  assign bus.res_data  = res_data_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with behavioural memories and quadrant.
// Build with or without SATURATE_EN; expectations follow the macro.
module tb_mac_sequencer;

  typedef struct {
    int          len;
    logic [11:0] in_base;
    logic [11:0] wt_base;
    logic [15:0] in_w;
    logic [15:0] wt_w;
    logic [15:0] exp_data;
    logic        exp_sat;
  } vec_t;

`ifdef SATURATE_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  mac_sequencer_if #(.ADDR_W(12), .LEN_W(8)) bus ();

  mac_sequencer #(.ADDR_W(12), .LEN_W(8), .SHIFT(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [15:0] in_mem [0:4095];
  logic [15:0] wt_mem [0:4095];

  // Synchronous single-port memories.
  always @(posedge clock) begin
    if (bus.mem_rd_en) begin
      bus.in_data <= in_mem[bus.in_addr];
      bus.wt_data <= wt_mem[bus.wt_addr];
    end
  end

  // Quadrant: accumulates every cycle, replaces on clear; not reset on purpose.
  logic signed [31:0] prod;
  assign prod = $signed(bus.mac_a) * $signed(bus.mac_b);
  always @(posedge clock) begin
    bus.mac_acc <= bus.mac_clear ? prod : bus.mac_acc + prod;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Strobe monitor: address sequence and activity counts for the current run.
  bit          mon_on = 1'b0;
  int          rd_cnt;
  int          clr_cnt;
  logic [11:0] mon_in_base, mon_wt_base;

  always @(negedge clock) begin
    if (mon_on) begin
      if (bus.mem_rd_en) begin
        chk("in_addr", {20'd0, bus.in_addr}, {20'd0, 12'(mon_in_base + 12'(rd_cnt))});
        chk("wt_addr", {20'd0, bus.wt_addr}, {20'd0, 12'(mon_wt_base + 12'(rd_cnt))});
        rd_cnt++;
      end
      if (bus.mac_clear) clr_cnt++;
    end
  end

  task automatic load_mem(input vec_t v);
    for (int a = 0; a < 4096; a++) begin
      in_mem[a] = 16'h0300;
      wt_mem[a] = 16'h0300;
    end
    for (int i = 0; i < v.len; i++) begin
      in_mem[12'(v.in_base + 12'(i))] = v.in_w;
      wt_mem[12'(v.wt_base + 12'(i))] = v.wt_w;
    end
  endtask

  // Pulses start in cycle 0; returns at the negedge of cycle 1.
  task automatic start_run(input vec_t v);
    @(negedge clock);
    bus.start       = 1'b1;
    bus.cfg_len     = 8'(v.len);
    bus.cfg_in_base = v.in_base;
    bus.cfg_wt_base = v.wt_base;
    mon_in_base     = v.in_base;
    mon_wt_base     = v.wt_base;
    rd_cnt          = 0;
    clr_cnt         = 0;
    mon_on          = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.res_valid && lat < 200) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic run_and_check(input vec_t v, input string tag);
    int lat;
    load_mem(v);
    bus.res_ready = 1'b1;
    start_run(v);
    wait_valid(lat);
    chk({tag, ".latency"}, lat, (v.len == 0) ? 1 : v.len + 4);
    chk({tag, ".res_data"}, {16'd0, bus.res_data}, {16'd0, v.exp_data});
    chk({tag, ".res_sat"}, {31'd0, bus.res_sat}, {31'd0, v.exp_sat});
    @(negedge clock);
    chk({tag, ".busy_after"}, {31'd0, bus.busy}, 32'd0);
    mon_on = 1'b0;
    chk({tag, ".rd_count"}, rd_cnt, v.len);
    chk({tag, ".clear_count"}, clr_cnt, (v.len > 0) ? 1 : 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, ".busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, ".mem_rd_en"}, {31'd0, bus.mem_rd_en}, 32'd0);
    chk({tag, ".addrs"}, {8'd0, bus.in_addr, bus.wt_addr}, 32'd0);
    chk({tag, ".mac_ab"}, {bus.mac_a, bus.mac_b}, 32'd0);
    chk({tag, ".mac_clear"}, {31'd0, bus.mac_clear}, 32'd0);
    chk({tag, ".res_valid"}, {31'd0, bus.res_valid}, 32'd0);
    chk({tag, ".res_data"}, {16'd0, bus.res_data}, 32'd0);
    chk({tag, ".res_sat"}, {31'd0, bus.res_sat}, 32'd0);
  endtask

  vec_t vecs[9];

  initial begin
    int          lat;
    logic [31:0] acc0;

    vecs[0] = '{1, 12'h000, 12'h100, 16'h0100, 16'h0200, 16'h0200, 1'b0};
    vecs[1] = '{4, 12'h010, 12'h800, 16'h0100, 16'h0100, 16'h0400, 1'b0};
    vecs[2] = '{0, 12'h020, 12'h030, 16'h0100, 16'h0100, 16'h0000, 1'b0};
    vecs[3] = '{2, 12'h040, 12'h050, 16'h7f00, 16'h7f00,
                SatEn ? 16'h7fff : 16'h0200, SatEn};
    vecs[4] = '{3, 12'hffe, 12'h7ff, 16'hff00, 16'h0300, 16'hf700, 1'b0};
    vecs[5] = '{8, 12'h200, 12'h300, 16'h0080, 16'h0040, 16'h0100, 1'b0};
    vecs[6] = '{2, 12'h400, 12'h500, 16'h8000, 16'h7fff,
                SatEn ? 16'h8000 : 16'h0100, SatEn};
    vecs[7] = '{1, 12'h600, 12'h601, 16'h7fff, 16'h0100, 16'h7fff, 1'b0};
    vecs[8] = '{1, 12'h700, 12'h701, 16'h4000, 16'h0200,
                SatEn ? 16'h7fff : 16'h8000, SatEn};

    reset_n         = 1'b0;
    bus.start       = 1'b0;
    bus.cfg_len     = '0;
    bus.cfg_in_base = '0;
    bus.cfg_wt_base = '0;
    bus.res_ready   = 1'b1;
    #12;
    chk_outputs_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;

    for (int k = 0; k < 9; k++) begin
      run_and_check(vecs[k], $sformatf("vec%0d", k));
    end

    // Backpressure: result and accumulator frozen, start ignored while busy.
    load_mem(vecs[0]);
    bus.res_ready = 1'b0;
    start_run(vecs[0]);
    wait_valid(lat);
    chk("bp.latency", lat, 5);
    acc0 = bus.mac_acc;
    for (int k = 0; k < 10; k++) begin
      bus.start   = (k % 3 == 0);
      bus.cfg_len = 8'd5;
      @(negedge clock);
      chk("bp.res_valid", {31'd0, bus.res_valid}, 32'd1);
      chk("bp.res_data", {16'd0, bus.res_data}, 32'h0200);
      chk("bp.mac_acc", bus.mac_acc, acc0);
      chk("bp.mem_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
    end
    bus.start     = 1'b1;
    bus.res_ready = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    chk("bp.busy_after", {31'd0, bus.busy}, 32'd0);
    @(negedge clock);
    chk("bp.still_idle", {31'd0, bus.busy}, 32'd0);
    mon_on = 1'b0;
    chk("bp.rd_count", rd_cnt, 1);
    run_and_check(vecs[1], "bp.next");

    // Reset in the middle of an N=8 run, then a fresh N=1 run.
    load_mem(vecs[5]);
    start_run(vecs[5]);
    @(negedge clock);
    chk("rst.busy_before", {31'd0, bus.busy}, 32'd1);
    chk("rst.rd_en_before", {31'd0, bus.mem_rd_en}, 32'd1);
    mon_on  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_outputs_zero("midrun_reset");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    run_and_check(vecs[0], "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
